// File: rtl/spi_sprite_sequencer.sv
// Turns the parsed SPI byte stream into sprite RAM writes (SAVE_SPRITE) and
// queued draw requests (DRAW_SPRITE) for the renderer.
module spi_sprite_sequencer #(
    parameter int unsigned NUM_SPRITES    = 16,
    parameter int unsigned PIX_PER_SPRITE = 512,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [7:0]  CMD_SAVE       = 8'h01,
    parameter logic [7:0]  CMD_DRAW       = 8'h02,
    localparam int unsigned SID_W = $clog2(NUM_SPRITES),
    localparam int unsigned PIX_W = $clog2(PIX_PER_SPRITE)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   abort,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_command,
    input  logic [7:0]             rx_data,
    input  logic [15:0]            rx_index,
    output logic                   spr_we,
    output logic [SID_W+PIX_W-1:0] spr_addr,
    output logic [7:0]             spr_wdata,
    output logic                   draw_valid,
    input  logic                   draw_ready,
    output logic [SID_W-1:0]       draw_sprite,
    output logic [15:0]            draw_x,
    output logic [15:0]            draw_y,
    output logic [7:0]             draw_flags,
    output logic                   err_bad_id,
    output logic                   err_proto,
    output logic                   err_overflow,
    input  logic                   clr_err
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam logic [15:0] LAST_PIX_IDX = 16'(PIX_PER_SPRITE + 1);

    typedef enum logic [1:0] {S_IDLE, S_SAVE_ID, S_SAVE_PIX, S_DRAW} state_t;

    typedef struct packed {
        logic [SID_W-1:0] sid;
        logic [15:0]      x;
        logic [15:0]      y;
        logic [7:0]       flags;
    } req_t;

    state_t                   state_q, state_d;
    logic [15:0]              exp_q, exp_d;
    logic [SID_W-1:0]         sid_q, sid_d;
    logic                     bad_q, bad_d;
    logic [15:0]              dx_q, dx_d, dy_q, dy_d;
    logic                     spr_we_q, spr_we_d;
    logic [SID_W+PIX_W-1:0]   spr_addr_q, spr_addr_d;
    logic [7:0]               spr_wdata_q, spr_wdata_d;
    logic                     push_q, push_d;
    req_t                     ent_q, ent_d;
    logic                     err_bad_q, err_proto_q, err_ovf_q;
    logic                     set_bad, set_proto, set_ovf;
    logic                     id_oob;
    logic [PIX_W-1:0]         pix_off;

    req_t                     mem [FIFO_DEPTH];
    logic [AW-1:0]            rd_q, wr_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     full, pop, push_ok;
    req_t                     head;

    assign id_oob  = {1'b0, rx_data} >= 9'(NUM_SPRITES);
    assign pix_off = PIX_W'(rx_index - 16'd2);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        sid_d       = sid_q;
        bad_d       = bad_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        spr_we_d    = 1'b0;
        spr_addr_d  = spr_addr_q;
        spr_wdata_d = spr_wdata_q;
        push_d      = 1'b0;
        ent_d       = ent_q;
        set_bad     = 1'b0;
        set_proto   = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else if (rx_valid) begin
            if (rx_index == 16'd0) begin
                exp_d = 16'd1;
                if (rx_command == CMD_SAVE)      state_d = S_SAVE_ID;
                else if (rx_command == CMD_DRAW) state_d = S_DRAW;
                else                             state_d = S_IDLE;
            end else if (state_q == S_IDLE || rx_index != exp_q) begin
                set_proto = 1'b1;
                state_d   = S_IDLE;
            end else begin
                exp_d = exp_q + 16'd1;
                case (state_q)
                    S_SAVE_ID: begin
                        sid_d   = rx_data[SID_W-1:0];
                        bad_d   = id_oob;
                        set_bad = id_oob;
                        state_d = S_SAVE_PIX;
                    end
                    S_SAVE_PIX: begin
                        // Out-of-range sprite ids still consume their pixels, silently.
                        if (!bad_q) begin
                            spr_we_d    = 1'b1;
                            spr_addr_d  = {sid_q, pix_off};
                            spr_wdata_d = rx_data;
                        end
                        if (rx_index == LAST_PIX_IDX) state_d = S_IDLE;
                    end
                    S_DRAW: begin
                        case (rx_index)
                            16'd1: begin
                                sid_d = rx_data[SID_W-1:0];
                                bad_d = id_oob;
                            end
                            16'd2: dx_d[15:8] = rx_data;
                            16'd3: dx_d[7:0]  = rx_data;
                            16'd4: dy_d[15:8] = rx_data;
                            16'd5: dy_d[7:0]  = rx_data;
                            16'd6: begin
                                if (bad_q) begin
                                    set_bad = 1'b1;
                                end else begin
                                    push_d = 1'b1;
                                    ent_d  = '{sid: sid_q, x: dx_q, y: dy_q, flags: rx_data};
                                end
                                state_d = S_IDLE;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            exp_q       <= '0;
            sid_q       <= '0;
            bad_q       <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            spr_we_q    <= 1'b0;
            spr_addr_q  <= '0;
            spr_wdata_q <= '0;
            push_q      <= 1'b0;
            ent_q       <= '0;
            err_bad_q   <= 1'b0;
            err_proto_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            sid_q       <= sid_d;
            bad_q       <= bad_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            spr_we_q    <= spr_we_d;
            spr_addr_q  <= spr_addr_d;
            spr_wdata_q <= spr_wdata_d;
            push_q      <= push_d;
            ent_q       <= ent_d;
            err_bad_q   <= (err_bad_q   & ~clr_err) | set_bad;
            err_proto_q <= (err_proto_q & ~clr_err) | set_proto;
            err_ovf_q   <= (err_ovf_q   & ~clr_err) | set_ovf;
        end
    end

    // Draw FIFO: a pop in the same cycle frees the slot for a push into a full queue.
    assign full    = cnt_q == CNT_W'(FIFO_DEPTH);
    assign pop     = (cnt_q != '0) && draw_ready;
    assign push_ok = push_q && (!full || pop);
    assign set_ovf = push_q && full && !pop;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_ok) mem[wr_q] <= ent_q;
    end

    assign head        = mem[rd_q];
    assign draw_valid  = cnt_q != '0;
    assign draw_sprite = draw_valid ? head.sid   : '0;
    assign draw_x      = draw_valid ? head.x     : '0;
    assign draw_y      = draw_valid ? head.y     : '0;
    assign draw_flags  = draw_valid ? head.flags : '0;

    assign spr_we       = spr_we_q;
    assign spr_addr     = spr_addr_q;
    assign spr_wdata    = spr_wdata_q;
    assign err_bad_id   = err_bad_q;
    assign err_proto    = err_proto_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_spi_sprite_sequencer.sv
// Bench for spi_sprite_sequencer: command-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_spi_sprite_sequencer;

    localparam int NSPR  = 16;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_command = '0;
    logic [7:0]  rx_data = '0;
    logic [15:0] rx_index = '0;
    logic        spr_we;
    logic [12:0] spr_addr;
    logic [7:0]  spr_wdata;
    logic        draw_valid;
    logic        draw_ready = 1'b0;
    logic [3:0]  draw_sprite;
    logic [15:0] draw_x, draw_y;
    logic [7:0]  draw_flags;
    logic        err_bad_id, err_proto, err_overflow;
    logic        clr_err = 1'b0;

    spi_sprite_sequencer #(.NUM_SPRITES(16), .PIX_PER_SPRITE(512), .FIFO_DEPTH(4),
                           .CMD_SAVE(8'h01), .CMD_DRAW(8'h02)) dut (
        .clock(clock), .reset(reset), .abort(abort),
        .rx_valid(rx_valid), .rx_command(rx_command), .rx_data(rx_data), .rx_index(rx_index),
        .spr_we(spr_we), .spr_addr(spr_addr), .spr_wdata(spr_wdata),
        .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_sprite(draw_sprite),
        .draw_x(draw_x), .draw_y(draw_y), .draw_flags(draw_flags),
        .err_bad_id(err_bad_id), .err_proto(err_proto), .err_overflow(err_overflow),
        .clr_err(clr_err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command is an opcode plus the list of data bytes accepted so far.
    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  f;
    } req_t;

    int          m_op;
    logic [7:0]  m_bytes[$];
    bit          m_we;
    logic [12:0] m_addr;
    logic [7:0]  m_wd;
    req_t        m_q[$];
    bit          m_pend;
    req_t        m_pend_r;
    bit          e_bad, e_proto, e_ovf;

    always @(posedge clock) begin
        bit sb, sp, so;
        logic [7:0] id0;
        sb = 0; sp = 0; so = 0;
        if (reset) begin
            m_op = 0; m_bytes.delete(); m_we = 0; m_addr = '0; m_wd = '0;
            m_q.delete(); m_pend = 0; e_bad = 0; e_proto = 0; e_ovf = 0;
        end else begin
            if (m_q.size() > 0 && draw_ready) void'(m_q.pop_front());
            if (m_pend) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pend_r);
                else so = 1;
            end
            m_pend = 0;
            m_we = 0;
            if (abort) begin
                m_op = 0;
            end else if (rx_valid) begin
                if (rx_index == 0) begin
                    m_op = (rx_command == 8'h01) ? 1 : (rx_command == 8'h02) ? 2 : 0;
                    m_bytes.delete();
                end else if (m_op == 0 || int'(rx_index) != m_bytes.size() + 1) begin
                    sp = 1;
                    m_op = 0;
                end else begin
                    m_bytes.push_back(rx_data);
                    id0 = m_bytes[0];
                    if (m_op == 1) begin
                        if (rx_index == 1) sb = (id0 >= NSPR);
                        else begin
                            if (id0 < NSPR) begin
                                m_we = 1;
                                m_addr = 13'(int'(id0) * 512 + int'(rx_index) - 2);
                                m_wd = rx_data;
                            end
                            if (rx_index == 513) m_op = 0;
                        end
                    end else if (rx_index == 6) begin
                        if (id0 >= NSPR) sb = 1;
                        else begin
                            m_pend = 1;
                            m_pend_r = '{id: id0[3:0], x: {m_bytes[1], m_bytes[2]},
                                         y: {m_bytes[3], m_bytes[4]}, f: m_bytes[5]};
                        end
                        m_op = 0;
                    end
                end
            end
            e_bad   = (e_bad   & ~clr_err) | sb;
            e_proto = (e_proto & ~clr_err) | sp;
            e_ovf   = (e_ovf   & ~clr_err) | so;
        end
    end

    always @(negedge clock) begin
        req_t h;
        if (chk_en) begin
            chk("spr_we", 32'(spr_we), 32'(m_we));
            if (m_we) begin
                chk("spr_addr", 32'(spr_addr), 32'(m_addr));
                chk("spr_wdata", 32'(spr_wdata), 32'(m_wd));
            end
            chk("draw_valid", 32'(draw_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                h = m_q[0];
                chk("draw_sprite", 32'(draw_sprite), 32'(h.id));
                chk("draw_x", 32'(draw_x), 32'(h.x));
                chk("draw_y", 32'(draw_y), 32'(h.y));
                chk("draw_flags", 32'(draw_flags), 32'(h.f));
            end
            chk("err_bad_id", 32'(err_bad_id), 32'(e_bad));
            chk("err_proto", 32'(err_proto), 32'(e_proto));
            chk("err_overflow", 32'(err_overflow), 32'(e_ovf));
        end
    end

    int we_cnt = 0;
    logic [12:0] we_first, we_last;
    always @(negedge clock) begin
        if (spr_we) begin
            we_cnt++;
            if (we_cnt == 1) we_first = spr_addr;
            we_last = spr_addr;
        end
    end

    always @(negedge clock) begin
        if (rnd_ready) begin
            draw_ready = ($urandom_range(0, 2) != 0);
            clr_err    = ($urandom_range(0, 40) == 0);
        end
    end

    task automatic put(input logic [7:0] cmd, input logic [7:0] d, input logic [15:0] idx);
        rx_valid = 1'b1; rx_command = cmd; rx_data = d; rx_index = idx;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic clr();
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
    endtask

    task automatic draw_cmd(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                            input logic [7:0] f);
        put(8'h02, 8'h00, 16'd0); put(8'h02, id, 16'd1);
        put(8'h02, x[15:8], 16'd2); put(8'h02, x[7:0], 16'd3);
        put(8'h02, y[15:8], 16'd4); put(8'h02, y[7:0], 16'd5);
        put(8'h02, f, 16'd6);
    endtask

    task automatic save_cmd(input logic [7:0] id, input int npix);
        put(8'h01, 8'h00, 16'd0); put(8'h01, id, 16'd1);
        for (int i = 0; i < npix; i++) put(8'h01, 8'(i), 16'(i + 2));
    endtask

    // Random command with occasional skipped indices, gaps and aborts.
    task automatic rnd_cmd(input logic [7:0] cmd, input logic [7:0] id, input int nbytes);
        logic [15:0] idx;
        logic [7:0]  d;
        for (int i = 0; i <= nbytes; i++) begin
            idx = 16'(i);
            d = (i == 1) ? id : 8'($urandom);
            if ($urandom_range(0, 60) == 0) idx = idx + 16'd1;
            if ($urandom_range(0, 80) == 0) begin
                abort = 1'b1;
                repeat ($urandom_range(1, 2)) put(cmd, 8'($urandom), 16'($urandom_range(0, 7)));
                abort = 1'b0;
            end
            put(cmd, d, idx);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, n;
        logic [7:0] id;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;
        idle(1);
        chk("rst_we", 32'(spr_we), 32'd0);
        chk("rst_addr", 32'(spr_addr), 32'd0);
        chk("rst_wdata", 32'(spr_wdata), 32'd0);
        chk("rst_dvalid", 32'(draw_valid), 32'd0);
        chk("rst_dfields", {draw_x, draw_y}, 32'd0);
        chk("rst_errs", 32'({err_bad_id, err_proto, err_overflow}), 32'd0);

        // Full save of sprite 3, back-to-back bytes
        we_cnt = 0;
        save_cmd(8'h03, 512);
        idle(2);
        chk("save_count", 32'(we_cnt), 32'd512);
        chk("save_first", 32'(we_first), 32'h600);
        chk("save_last", 32'(we_last), 32'h7FF);
        put(8'h01, 8'h00, 16'd514);
        idle(1);
        chk("save_then_idle_proto", 32'(err_proto), 32'd1);
        clr();

        // Single draw, latency and hold
        draw_cmd(8'h05, 16'd300, 16'd240, 8'h80);
        chk("draw_lat1", 32'(draw_valid), 32'd0);
        idle(1);
        chk("draw_lat2", 32'(draw_valid), 32'd1);
        chk("draw_spr", 32'(draw_sprite), 32'd5);
        chk("draw_x_lit", 32'(draw_x), 32'd300);
        chk("draw_y_lit", 32'(draw_y), 32'd240);
        chk("draw_f_lit", 32'(draw_flags), 32'h80);
        idle(3);
        chk("draw_hold", 32'(draw_valid), 32'd1);
        draw_ready = 1'b1; idle(1); draw_ready = 1'b0;
        chk("draw_popped", 32'(draw_valid), 32'd0);

        // Overflow
        for (int i = 1; i <= 5; i++) draw_cmd(8'(i), 16'(i * 10), 16'(i), 8'(i));
        idle(2);
        chk("ovf_set", 32'(err_overflow), 32'd1);
        chk("ovf_head", 32'(draw_sprite), 32'd1);
        draw_cmd(8'h06, 16'd60, 16'd6, 8'h06);
        draw_ready = 1'b1; idle(1); draw_ready = 1'b0;
        idle(1);
        chk("ovf_pop_head", 32'(draw_sprite), 32'd2);
        chk("ovf_sticky", 32'(err_overflow), 32'd1);
        clr();
        chk("ovf_clr", 32'(err_overflow), 32'd0);
        draw_ready = 1'b1; idle(6); draw_ready = 1'b0;
        chk("ovf_drained", 32'(draw_valid), 32'd0);

        // Bad ids
        we_cnt = 0;
        save_cmd(8'h20, 512);
        idle(2);
        chk("bad_save_nowe", 32'(we_cnt), 32'd0);
        chk("bad_save_err", 32'(err_bad_id), 32'd1);
        clr();
        draw_cmd(8'h10, 16'd1, 16'd2, 8'h03);
        idle(3);
        chk("bad_draw_nopush", 32'(draw_valid), 32'd0);
        chk("bad_draw_err", 32'(err_bad_id), 32'd1);
        clr();

        // Abort mid-save and mid-draw
        save_cmd(8'h07, 99);
        abort = 1'b1;
        for (int i = 101; i < 104; i++) begin
            put(8'h01, 8'hAA, 16'(i));
            chk("abort_nowe", 32'(spr_we), 32'd0);
        end
        abort = 1'b0;
        idle(1);
        put(8'h02, 8'h00, 16'd0); put(8'h02, 8'h04, 16'd1);
        put(8'h02, 8'h00, 16'd2); put(8'h02, 8'h01, 16'd3);
        abort = 1'b1; idle(2); abort = 1'b0;
        idle(2);
        chk("abort_nopush", 32'(draw_valid), 32'd0);
        draw_cmd(8'h09, 16'h1234, 16'h0042, 8'h11);
        idle(1);
        chk("abort_after_spr", 32'(draw_sprite), 32'd9);
        chk("abort_after_x", 32'(draw_x), 32'h1234);
        chk("abort_no_proto", 32'(err_proto), 32'd0);
        draw_ready = 1'b1; idle(1); draw_ready = 1'b0;

        // Protocol errors and mid-command restart
        put(8'h02, 8'h00, 16'd0); put(8'h02, 8'h02, 16'd1);
        put(8'h02, 8'h00, 16'd2); put(8'h02, 8'h00, 16'd4);
        put(8'h02, 8'h00, 16'd5); put(8'h02, 8'h00, 16'd6);
        idle(3);
        chk("proto_set", 32'(err_proto), 32'd1);
        chk("proto_nopush", 32'(draw_valid), 32'd0);
        clr();
        save_cmd(8'h02, 9);
        draw_cmd(8'h04, 16'd7, 16'd8, 8'h09);
        idle(1);
        chk("restart_no_proto", 32'(err_proto), 32'd0);
        chk("restart_spr", 32'(draw_sprite), 32'd4);
        draw_ready = 1'b1; idle(1); draw_ready = 1'b0;

        // Randomized traffic
        rnd_ready = 1'b1;
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            id = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            if (op < 4) begin
                n = ($urandom_range(0, 15) == 0) ? 513 : $urandom_range(1, 20);
                rnd_cmd(8'h01, id, n);
            end else if (op < 9) begin
                rnd_cmd(8'h02, id, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 6);
            end else begin
                rnd_cmd(8'($urandom_range(3, 255)), id, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 10) == 0) idle($urandom_range(1, 4));
        end
        rnd_ready = 1'b0;
        clr_err = 1'b0;
        draw_ready = 1'b0;
        idle(2);

        // Reset takes priority over traffic
        draw_cmd(8'h01, 16'd1, 16'd1, 8'h01);
        reset = 1'b1;
        put(8'h02, 8'h00, 16'd0);
        put(8'h02, 8'h03, 16'd1);
        reset = 1'b0;
        idle(1);
        chk("rst2_dvalid", 32'(draw_valid), 32'd0);
        chk("rst2_errs", 32'({err_bad_id, err_proto, err_overflow}), 32'd0);
        chk("rst2_we", 32'(spr_we), 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_sprite_sequencer.md
Name: spi_sprite_sequencer

Overview:
- Consumes the parsed SPI byte stream (command byte plus indexed data bytes) and turns it into actions.
- SAVE_SPRITE commands become a sequence of writes to the sprite pixel RAM.
- DRAW_SPRITE commands are collected into complete draw requests and queued in a small FIFO for the renderer.
- Sits between the SPI receive path and the sprite RAM / draw engine; it is the only writer of sprite RAM on the SPI side.

Parameters:
- NUM_SPRITES, 16, number of sprite slots; SID_W = $clog2(NUM_SPRITES).
- PIX_PER_SPRITE, 512, pixel bytes per sprite; PIX_W = 9.
- FIFO_DEPTH, 4, draw-request queue entries (power of two, ≥2).
- CMD_SAVE, 8'h01, SAVE_SPRITE opcode.
- CMD_DRAW, 8'h02, DRAW_SPRITE opcode.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- abort  in  1  level; high while SPI chip-select is inactive; discards any command in progress
- rx_valid  in  1  one-cycle pulse per received byte
- rx_command  in  8  opcode of the current command, valid with rx_valid
- rx_data  in  8  received byte
- rx_index  in  16  0 = command byte itself; 1..N = data byte number within the command
- spr_we  out  1  sprite RAM write strobe
- spr_addr  out  SID_W+PIX_W  {sprite_id, pixel_index}
- spr_wdata  out  8  pixel byte
- draw_valid  out  1  FIFO head valid
- draw_ready  in  1  consumer accepts the head when draw_valid & draw_ready
- draw_sprite  out  SID_W  sprite id of head entry
- draw_x  out  16  x of head entry
- draw_y  out  16  y of head entry
- draw_flags  out  8  flags/layer of head entry
- err_bad_id  out  1  sticky: sprite id ≥ NUM_SPRITES
- err_proto  out  1  sticky: unexpected rx_index
- err_overflow  out  1  sticky: draw dropped because the FIFO was full
- clr_err  in  1  clears all sticky errors

Behaviour:
- Reset: state IDLE, FIFO empty, spr_we=0, spr_addr=0, spr_wdata=0, draw_valid=0, draw_* head fields=0, all err_*=0. Reset has priority over every other input.
- Handling of each rx_valid byte:
  - rx_index==0: treated as a command byte in any state, so a new command always restarts the FSM.
    - rx_command==CMD_SAVE → SAVE_ID.
    - rx_command==CMD_DRAW → DRAW.
    - Any other opcode → IDLE.
  - SAVE_ID, rx_index==1: latch sprite_id=rx_data[SID_W-1:0] → SAVE_PIX. If rx_data ≥ NUM_SPRITES, set err_bad_id and go to SAVE_PIX with writes suppressed.
  - SAVE_PIX, rx_index in 2..513: next cycle spr_we=1 (one-cycle pulse), spr_addr={sprite_id, rx_index-2}, spr_wdata=rx_data. Write latency is exactly 1 cycle after rx_valid. At rx_index==513 → IDLE.
  - DRAW, rx_index 1..6 fill a shadow register:
    - 1 = id
    - 2 = x[15:8], 3 = x[7:0]
    - 4 = y[15:8], 5 = y[7:0]
    - 6 = flags
  - On index 6: push {id, x, y, flags} into the FIFO on the next cycle → IDLE. If id ≥ NUM_SPRITES, do not push and set err_bad_id.
  - Any data byte whose rx_index ≠ expected next index (including any data byte in IDLE): set err_proto, → IDLE, no write or push for that byte.
- abort high: FSM → IDLE, partial draw shadow discarded, no spr_we. FIFO contents are kept. rx_valid is ignored while abort is high.
- FIFO:
  - Push when not full.
  - Push when full with draw_ready & draw_valid in the same cycle is accepted (pop first).
  - Push when full without a pop drops the entry and sets err_overflow.
  - draw_* always reflect the head entry; draw_valid = !empty.
  - An entry is visible on draw_valid 2 cycles after the rx_valid of byte 6 when the FIFO was empty.
- Sticky errors: set-over-clear. If clr_err and a set event occur in the same cycle, the error stays 1.
- Consecutive rx_valid on back-to-back cycles must be supported: no bubbles, one write per cycle.

Test Plan:
- Save, sprite 3: cmd 0x01 idx0, id 0x03 idx1, bytes 0x00..0xFF×2 at idx 2..513 → 512 spr_we pulses, spr_addr 0x600..0x7FF, wdata matches, each 1 cycle after rx_valid; then IDLE.
- Draw: cmd 0x02, bytes 05 01 2C 00 F0 80 → draw_valid 2 cycles after the last byte with sprite=5, x=300, y=240, flags=0x80. Holding draw_ready=0 keeps the entry; draw_ready=1 empties the FIFO.
- Overflow: 5 draws with draw_ready=0 (FIFO_DEPTH=4) → 4 queued, err_overflow=1, 5th lost. A 6th draw pushed in a cycle with draw_ready=1 while full is accepted, and err_overflow stays set until clr_err.
- Bad id: save with id 0x20 → zero spr_we over 512 bytes, err_bad_id=1. Draw with id 0x10 → no push.
- Abort: abort mid-save after idx 100 and mid-draw after idx 3 → writes stop immediately, no FIFO push. A new command afterward works normally.
- Protocol: draw data jumping from idx 2 to idx 4 → err_proto=1, no push. A command byte arriving mid-save restarts cleanly with no err_proto.
